ps2_keyboard_rx: RTL and testbench
==================================

PS2_KEYBOARD_RX -- requirements
Module: ps2_keyboard_rx

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: consecutive equal samples needed to accept a ps2_clk level change.
REQ-002 SHALL have parameter TIMEOUT, default 13000: clk_sys cycles without a filtered falling edge before an in-progress frame aborts (about 250 us at 52 MHz).
REQ-003 SHALL have port clk_sys, input, 1: the only clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port ps2_clk, input, 1: raw PS/2 clock from the pin, asynchronous.
REQ-006 SHALL have port ps2_data, input, 1: raw PS/2 data from the pin, asynchronous.
REQ-007 SHALL have port ps2_key, output, 11: bit 10 toggle strobe, bit 9 pressed, bit 8 extended (E0), bits 7:0 scancode.
REQ-008 SHALL have port err, output, 1: one-cycle pulse on a framing, parity or timeout error.
REQ-009 SHALL have port busy, output, 1: high while a frame is in progress (any state other than IDLE).

Function
REQ-010 SHALL pass ps2_clk and ps2_data through 2-flop synchronisers, both reset to 1.
REQ-011 SHALL filter the synchronised clock: the filtered level changes only after FILTER_LEN consecutive samples at the new level; shorter glitches are ignored.
REQ-012 SHALL sample synchronised data in the cycle the filtered clock goes from 1 to 0 ("edge cycle").
REQ-013 SHALL implement the states IDLE, DATA, PARITY and STOP with these transitions:
- IDLE: on an edge with data=0, go to DATA with bit count 0; with data=1, stay in IDLE, no err.
- DATA: shift data in LSB first; after 8 bits, go to PARITY.
- PARITY: capture the bit, go to STOP.
- STOP: return to IDLE; stop=0 -> err pulse and frame dropped.
REQ-014 SHALL check odd parity: the XOR of the 8 data bits and the parity bit SHALL be 1 (see REQ-024).
REQ-015 SHALL reset the timeout counter on every edge cycle; when it reaches TIMEOUT outside IDLE, go to IDLE and pulse err without publishing.
REQ-016 SHALL let an edge win over timeout when both occur in the same cycle.
REQ-017 SHALL handle a valid byte as follows:
- 0xE0: set ext flag, no publish.
- 0xF0: set rel flag, no publish.
- 0xE1: dropped, flags unchanged.
- 0x00, 0xAA, 0xEE, 0xFA, 0xFE, 0xFF: dropped, both flags cleared.
- Any other byte: publish, then clear both flags.
REQ-018 SHALL publish as ps2_key <= {~ps2_key[10], ~rel, ext, byte}, registered and visible on the cycle after the STOP edge cycle.
REQ-019 SHALL hold ps2_key unchanged between publishes; there is no backpressure, and consumers detect new data by a change in bit 10.
REQ-020 SHALL drive err for exactly one cycle per error event; errors SHALL NOT clear the ext/rel flags.

Reset
REQ-021 SHALL, while reset=0 at a clock edge, force the following:
- ps2_key = 11'h000; err = 0; busy = 0.
- State IDLE; bit count 0; ext = rel = 0.
- Timeout counter 0; filtered clock = 1; filter counter 0.
REQ-022 SHALL discard a frame interrupted by reset without publishing it; decoding SHALL resume with the next start bit after reset is released.

Configuration
REQ-023 SHALL make parity checking conditional on the macro PS2_RX_PARITY_CHECK_EN.
REQ-024 SHALL, with PS2_RX_PARITY_CHECK_EN defined, drop a frame with bad parity and pulse err in the cycle after the STOP edge cycle.
REQ-025 SHALL, without PS2_RX_PARITY_CHECK_EN defined, capture the parity bit but ignore it, and process every frame with stop=1 as valid.

Verification
REQ-026 SHALL cover: after reset, frame 0x1C with good parity -> ps2_key = 11'h61C one cycle after the stop edge; err stays 0.
REQ-027 SHALL cover: after REQ-026, frames E0, F0, 75 -> ps2_key = 11'h175 only after 0x75; unchanged after E0 and F0.
REQ-028 SHALL cover: frame 0x29 with even parity -> with the macro, err pulses once and ps2_key is unchanged; without the macro, ps2_key = {~bit10, 1, 0, 8'h29}.
REQ-029 SHALL cover: start bit plus 5 data bits, then the clock held high for TIMEOUT+10 cycles -> one err pulse, busy=0; a following 0x16 frame publishes pressed 0x16.
REQ-030 SHALL cover: 3-cycle low glitches on ps2_clk during a frame (FILTER_LEN=8) -> no extra bits; the frame decodes correctly.
REQ-031 SHALL cover: reset=0 for one cycle after the 4th data bit -> ps2_key = 0 and busy = 0; the next 0x1C frame gives 11'h61C.

Source files
------------

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises and filters the PS/2 lines, decodes 11-bit frames and
// publishes key events with E0/F0 prefix handling. Define PS2_RX_PARITY_CHECK_EN to drop bad-parity frames.
module ps2_keyboard_rx #(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 13000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        err,
  output logic        busy
);

  localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);
  localparam int unsigned ToW   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  // Bit [1] of each synchroniser is the usable value.
  logic [1:0]       clk_sync_q, data_sync_q;
  logic             filt_q, filt_d;
  logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
  logic             fall;
  logic             data_bit;
  state_e           state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic             ext_q, ext_d, rel_q, rel_d;
  logic [ToW-1:0]   to_cnt_q, to_cnt_d;
  logic [10:0]      key_q, key_d;
  logic             err_q, err_d;
  logic             parity_ok;

  assign data_bit = data_sync_q[1];

`ifdef PS2_RX_PARITY_CHECK_EN
  assign parity_ok = ^{shift_q, parity_q};
`else
  logic unused_parity;
  assign unused_parity = parity_q;
  assign parity_ok     = 1'b1;
`endif

  // Filtered clock flips only after FILTER_LEN consecutive samples at the new level.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    fall       = 1'b0;
    if (clk_sync_q[1] != filt_q) begin
      if (filt_cnt_q == FiltW'(FILTER_LEN - 1)) begin
        filt_d = clk_sync_q[1];
        fall   = filt_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    ext_d     = ext_q;
    rel_d     = rel_q;
    to_cnt_d  = to_cnt_q;
    key_d     = key_q;
    err_d     = 1'b0;
    if (fall) begin
      to_cnt_d = '0;
      unique case (state_q)
        StIdle: begin
          if (!data_bit) begin
            state_d   = StData;
            bit_cnt_d = '0;
          end
        end
        StData: begin
          shift_d   = {data_bit, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
        StParity: begin
          parity_d = data_bit;
          state_d  = StStop;
        end
        StStop: begin
          state_d = StIdle;
          if (!data_bit || !parity_ok) begin
            err_d = 1'b1;
          end else begin
            case (shift_q)
              8'hE0: ext_d = 1'b1;
              8'hF0: rel_d = 1'b1;
              8'hE1: begin end
              8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: begin
                ext_d = 1'b0;
                rel_d = 1'b0;
              end
              default: begin
                key_d = {~key_q[10], ~rel_q, ext_q, shift_q};
                ext_d = 1'b0;
                rel_d = 1'b0;
              end
            endcase
          end
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle) begin
      // Edge takes priority above; abort only on a quiet cycle.
      if (to_cnt_q == ToW'(TIMEOUT)) begin
        state_d  = StIdle;
        err_d    = 1'b1;
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= 1'b1;
      filt_cnt_q  <= '0;
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      ext_q       <= 1'b0;
      rel_q       <= 1'b0;
      to_cnt_q    <= '0;
      key_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      filt_q      <= filt_d;
      filt_cnt_q  <= filt_cnt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      ext_q       <= ext_d;
      rel_q       <= rel_d;
      to_cnt_q    <= to_cnt_d;
      key_q       <= key_d;
      err_q       <= err_d;
    end
  end

  assign ps2_key = key_q;
  assign err     = err_q;
  assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx: directed scenarios plus random frames scored against
// a byte-level model of the key-event protocol.
module tb_ps2_keyboard_rx;

  localparam int unsigned FLEN = 8;
  localparam int unsigned TMO  = 13000;
  localparam int          HALF = 30;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        err;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  int err_seen = 0;
  int err_wide = 0;
  logic err_prev = 1'b0;

  // Model state
  logic [10:0] exp_key;
  bit          m_ext, m_rel;
  int          exp_err;

  ps2_keyboard_rx #(
    .FILTER_LEN(FLEN),
    .TIMEOUT   (TMO)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .ps2_key (ps2_key),
    .err     (err),
    .busy    (busy)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (err) err_seen <= err_seen + 1;
    if (err && err_prev) err_wide <= err_wide + 1;
    err_prev <= err;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic model_reset();
    exp_key = '0;
    m_ext   = 1'b0;
    m_rel   = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad);
    bit drop;
    drop = stop_bad;
`ifdef PS2_RX_PARITY_CHECK_EN
    drop = drop | par_bad;
`endif
    if (drop) begin
      exp_err++;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_rel = 1'b1;
    end else if (b == 8'hE1) begin
    end else if (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF}) begin
      m_ext = 1'b0;
      m_rel = 1'b0;
    end else begin
      exp_key = {~exp_key[10], ~m_rel, m_ext, b};
      m_ext   = 1'b0;
      m_rel   = 1'b0;
    end
  endtask

  // Sends the first nbits bits of a frame; each bit is a high phase then a low phase.
  task automatic send_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad,
                            input int nbits, input bit glitch);
    logic [10:0] bits;
    bits = {~stop_bad, (~^b) ^ par_bad, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      if (glitch) begin
        wait_cyc(14);
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(HALF - 17);
      end else begin
        wait_cyc(HALF);
      end
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
    wait_cyc(HALF);
    ps2_data = 1'b1;
    wait_cyc(HALF);
  endtask

  task automatic frame_and_check(input string tag, input logic [7:0] b, input bit par_bad,
                                 input bit stop_bad, input bit glitch);
    send_frame(b, par_bad, stop_bad, 11, glitch);
    model_frame(b, par_bad, stop_bad);
    check_eq({tag, "_key"}, 32'(ps2_key), 32'(exp_key));
    check_eq({tag, "_err"}, err_seen, exp_err);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] specials [6];
    logic [7:0] b;
    int         r;
    specials = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
    exp_err  = 0;
    model_reset();

    wait_cyc(3);
    check_eq("rst_key", 32'(ps2_key), 32'h0);
    check_eq("rst_err", 32'(err), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    reset = 1'b1;
    wait_cyc(5);

    frame_and_check("f1c", 8'h1C, 1'b0, 1'b0, 1'b0);
    check_eq("f1c_lit", 32'(ps2_key), 32'h61C);

    frame_and_check("fe0", 8'hE0, 1'b0, 1'b0, 1'b0);
    check_eq("fe0_hold", 32'(ps2_key), 32'h61C);
    frame_and_check("ff0", 8'hF0, 1'b0, 1'b0, 1'b0);
    check_eq("ff0_hold", 32'(ps2_key), 32'h61C);
    frame_and_check("f75", 8'h75, 1'b0, 1'b0, 1'b0);
    check_eq("f75_lit", 32'(ps2_key), 32'h175);

    frame_and_check("f29_badpar", 8'h29, 1'b1, 1'b0, 1'b0);

    // Aborted frame: start plus five data bits, then silence.
    send_frame(8'h16, 1'b0, 1'b0, 6, 1'b0);
    check_eq("to_busy_mid", 32'(busy), 32'd1);
    wait_cyc(TMO + 10);
    exp_err++;
    check_eq("to_err", err_seen, exp_err);
    check_eq("to_busy", 32'(busy), 32'd0);
    check_eq("to_key", 32'(ps2_key), 32'(exp_key));
    frame_and_check("f16", 8'h16, 1'b0, 1'b0, 1'b0);

    frame_and_check("glitch", 8'h34, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of a frame.
    send_frame(8'h5A, 1'b0, 1'b0, 5, 1'b0);
    reset = 1'b0;
    wait_cyc(1);
    reset = 1'b1;
    wait_cyc(1);
    model_reset();
    check_eq("mrst_key", 32'(ps2_key), 32'h0);
    check_eq("mrst_busy", 32'(busy), 32'h0);
    wait_cyc(HALF);
    frame_and_check("mrst_f1c", 8'h1C, 1'b0, 1'b0, 1'b0);
    check_eq("mrst_lit", 32'(ps2_key), 32'h61C);

    for (int i = 0; i < 30; i++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0: b = 8'hE0;
        1: b = 8'hF0;
        2: b = 8'hE1;
        3: b = specials[$urandom_range(0, 5)];
        default: b = 8'($urandom);
      endcase
      frame_and_check("rnd", b, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
                      ($urandom_range(0, 3) == 0));
    end

    check_eq("err_width", err_wide, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
